// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding one UART TX FIFO from NREQ byte streams.
// Grants are packet-locked and revoked early when the owner stalls too long.
module uart_tx_arbiter #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [8*NREQ-1:0]     req_data,
    input  logic [NREQ-1:0]       req_last,
    output logic [NREQ-1:0]       req_ready,
    output logic [7:0]            fifo_data,
    output logic                  fifo_wr_en,
    input  logic                  fifo_full,
    output logic [NREQ-1:0]       grant,
    output logic                  busy,
    output logic                  timeout_evt
);

    localparam int unsigned IDX_W = $clog2(NREQ);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t            state_q, state_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]  gidx_q, gidx_d;
    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [7:0]        stall_q, stall_d;
    logic              timeout_q, timeout_d;

    logic              sel_found;
    logic [IDX_W-1:0]  sel_idx;
    logic [IDX_W-1:0]  cand_idx;
    logic              g_valid, g_last, xfer;
    logic [7:0]        g_data;
    logic [IDX_W-1:0]  next_ptr;

    assign g_valid  = req_valid[gidx_q];
    assign g_last   = req_last[gidx_q];
    assign g_data   = req_data[{gidx_q, 3'b000} +: 8];
    assign xfer     = (state_q == BUSY) && g_valid && !fifo_full;
    assign next_ptr = (gidx_q == IDX_W'(NREQ - 1)) ? '0 : gidx_q + 1'b1;

    // First valid requester starting at rr_ptr, wrapping modulo NREQ.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand_idx  = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand_idx = IDX_W'((32'(rr_ptr_q) + k) % NREQ);
            if (!sel_found && req_valid[cand_idx]) begin
                sel_found = 1'b1;
                sel_idx   = cand_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            gidx_q    <= '0;
            rr_ptr_q  <= '0;
            stall_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            gidx_q    <= gidx_d;
            rr_ptr_q  <= rr_ptr_d;
            stall_q   <= stall_d;
            timeout_q <= timeout_d;
        end
    end

    // A transfer takes priority over a timeout landing in the same cycle.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        gidx_d    = gidx_q;
        rr_ptr_d  = rr_ptr_q;
        stall_d   = stall_q;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (sel_found) begin
                    state_d = BUSY;
                    grant_d = NREQ'(1) << sel_idx;
                    gidx_d  = sel_idx;
                    stall_d = '0;
                end
            end
            BUSY: begin
                if (xfer) begin
                    stall_d = '0;
                    if (g_last) begin
                        state_d  = IDLE;
                        grant_d  = '0;
                        rr_ptr_d = next_ptr;
                    end
                end else if (stall_q == 8'(TIMEOUT)) begin
                    state_d   = IDLE;
                    grant_d   = '0;
                    rr_ptr_d  = next_ptr;
                    timeout_d = 1'b1;
                end else if (!g_valid && !fifo_full) begin
                    stall_d = stall_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are forced quiet while rst is held, even before the first edge.
    always_comb begin
        req_ready   = '0;
        fifo_wr_en  = 1'b0;
        fifo_data   = '0;
        grant       = '0;
        busy        = 1'b0;
        timeout_evt = 1'b0;
        if (!rst) begin
            grant       = grant_q;
            busy        = (state_q == BUSY);
            timeout_evt = timeout_q;
            if (state_q == BUSY) begin
                req_ready  = grant_q & {NREQ{!fifo_full}};
                fifo_wr_en = xfer;
                if (xfer)
                    fifo_data = g_data;
            end
        end
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters (2..8).
REQ-002 Parameter TIMEOUT, default 255: stall cycles before a granted packet is abandoned (1..255).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  NREQ  per-requester byte valid.
REQ-006 req_data  input  8*NREQ  per-requester byte; requester i on bits [8i+7:8i].
REQ-007 req_last  input  NREQ  marks final byte of requester's packet.
REQ-008 req_ready  output  NREQ  byte accepted when valid&ready.
REQ-009 fifo_data  output  8  byte to UART TX FIFO data input.
REQ-010 fifo_wr_en  output  1  one-cycle write strobe to UART TX FIFO.
REQ-011 fifo_full  input  1  UART TX FIFO full.
REQ-012 grant  output  NREQ  one-hot current owner; all-zero when idle.
REQ-013 busy  output  1  high while a packet is owned.
REQ-014 timeout_evt  output  1  one-cycle pulse when a grant is revoked by timeout.

Function
REQ-015 Two states, IDLE and BUSY; grant, state, rr_ptr, stall counter are registers.
REQ-016 IDLE: if any req_valid, select first asserted index scanning rr_ptr, rr_ptr+1, ... mod NREQ; next cycle state=BUSY, grant=one-hot(selected).
REQ-017 IDLE with no req_valid: remain IDLE, grant=0.
REQ-018 IDLE: req_ready=0, fifo_wr_en=0 (no byte passes in the arbitration cycle).
REQ-019 BUSY: req_ready[g]=!fifo_full for granted g; req_ready of all others=0.
REQ-020 BUSY: fifo_wr_en=req_valid[g]&!fifo_full, fifo_data=req_data[g], combinational same cycle; fifo_data=0 when fifo_wr_en=0.
REQ-021 Never assert fifo_wr_en while fifo_full=1.
REQ-022 Transfer with req_last[g]=1: next cycle IDLE, grant=0, rr_ptr=(g+1) mod NREQ.
REQ-023 Grant is packet-locked: other requesters' req_valid has no effect in BUSY.
REQ-024 Stall counter: cleared on entry to BUSY and on every transfer; increments each BUSY cycle with req_valid[g]=0; does not increment while fifo_full=1 (back-pressure is not a stall).
REQ-025 Stall counter reaching TIMEOUT: next cycle IDLE, grant=0, rr_ptr=(g+1) mod NREQ, timeout_evt=1 for exactly that one cycle.
REQ-026 Timeout and a transfer in the same cycle: transfer wins, counter clears, no timeout_evt.
REQ-027 busy = (state==BUSY).
REQ-028 Latency: req_valid rising in IDLE at cycle N gives earliest fifo_wr_en at cycle N+1; back-to-back packets from different requesters have one idle cycle between them.
REQ-029 Requester index wrap: NREQ-1 grant completion sets rr_ptr=0.

Reset
REQ-030 While rst=1: state=IDLE, grant=0, rr_ptr=0, stall counter=0, busy=0, timeout_evt=0, req_ready=0, fifo_wr_en=0, fifo_data=0.
REQ-031 rst mid-packet abandons the packet with no further writes; first cycle after rst deasserts behaves as IDLE with rr_ptr=0.

Verification
REQ-032 req_valid=4'b1010 after reset, packets of 2 bytes each -> grant 4'b0010, then 4'b1000; 4 writes in order, one idle cycle between packets.
REQ-033 All four requesters continuously valid with 1-byte packets -> grant order 0,1,2,3,0; no requester granted twice before all others served.
REQ-034 Requester 2 granted, fifo_full=1 for 300 cycles with req_valid=1 -> no writes, no timeout_evt; fifo_full drops -> byte written that cycle.
REQ-035 Requester 1 granted, sends 1 byte (not last) then drops req_valid -> timeout_evt after TIMEOUT=255 stall cycles, grant=0 next, next grant starts search at 2.
REQ-036 rst=1 asserted mid-packet with fifo_wr_en active -> fifo_wr_en=0 same cycle; after release, req_valid=4'b1111 -> grant 4'b0001.
REQ-037 Last byte and new req_valid from another requester in same cycle -> IDLE for one cycle, then grant to next index after finishing requester.
